// File: rtl/alu_program_sequencer.sv
// Program sequencer for the 8-bit ALU + result-register stage: issues stored
// {func, a} entries with a one-cycle load strobe. Optional early stop on a zero
// ALU result is enabled by defining ALU_SEQ_ZERO_HALT_EN.
module alu_program_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [6:0]        wr_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic [7:0]        alu_result,
  output logic [2:0]        func,
  output logic [3:0]        a_out,
  output logic              reg_load,
  output logic              reg_clear,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LEN_W-1:0]  len_q, len_d, len_eff;
  logic [6:0]        fa_q, fa_d;
  logic              load_q, load_d;
  logic              clear_q, clear_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              halt_q, halt_d;
  logic              last_entry;
  logic              zero_stop;

`ifdef ALU_SEQ_ZERO_HALT_EN
  assign zero_stop = (alu_result == 8'h00);
`else
  logic unused_alu_result;
  assign unused_alu_result = ^alu_result;
  assign zero_stop = 1'b0;
`endif

  assign len_eff    = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
  assign last_entry = ({1'b0, pc_q} == (len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    fa_d    = fa_q;
    halt_d  = halt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CLEAR;
          pc_d    = '0;
          halt_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        // Length is latched here so a mid-run change of prog_len has no effect.
        len_d   = len_eff;
        state_d = (len_eff == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (last_entry) begin
          state_d = S_DONE;
        end else if (zero_stop) begin
          state_d = S_DONE;
          halt_d  = 1'b1;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = step_mode ? S_WAIT : S_ISSUE;
        end
      end
      S_WAIT: begin
        if (step || !step_mode) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from the next state so the registered copies line up
    // with the state they describe.
    if (state_d == S_ISSUE) fa_d = mem_q[pc_d];
    load_d  = (state_d == S_ISSUE);
    clear_d = (state_d == S_CLEAR);
    busy_d  = (state_d == S_CLEAR) || (state_d == S_ISSUE) || (state_d == S_WAIT);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      fa_q    <= '0;
      load_q  <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      load_q  <= load_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      halt_q  <= halt_d;
    end
  end

  // Program storage and run length carry no reset; contents survive a reset.
  always_ff @(posedge CLK) begin
    len_q <= len_d;
    if (wr_en && ((state_q == S_IDLE) || (state_q == S_DONE)))
      mem_q[wr_addr] <= wr_data;
  end

  assign func      = fa_q[6:4];
  assign a_out     = fa_q[3:0];
  assign reg_load  = load_q;
  assign reg_clear = clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign halted    = halt_q;
  assign pc        = pc_q;

endmodule
